// File: rtl/onewire_master_if.sv
// onewire_master_if
// Bundles the command/response handshake and the pad signals of the
// 1-Wire bus initiator.
//   master : view used by onewire_master (takes commands, drives the pad)
//   slave  : view used by the local controller / pad wrapper
// Signals:
//   cmd_valid, cmd_op[1:0], cmd_bit   command request (0=RESET 1=WRITE 2=READ 3=reserved)
//   cmd_ready                         high while the initiator is idle
//   rsp_valid, rsp_bit, rsp_presence  completion pulse and sampled results
//   err_stuck                         pulse: bus was low when a command was accepted
//   pin_drive, pin_in                 open-drain pull-down enable and raw pad level
// Optional (macro ONEWIRE_STRONG_PULLUP_EN): cmd_spu request bit, spu output.
interface onewire_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_bit;
  logic       rsp_valid;
  logic       rsp_bit;
  logic       rsp_presence;
  logic       err_stuck;
  logic       pin_drive;
  logic       pin_in;
`ifdef ONEWIRE_STRONG_PULLUP_EN
  logic       cmd_spu;
  logic       spu;

  modport master (
    input  cmd_valid, cmd_op, cmd_bit, cmd_spu, pin_in,
    output cmd_ready, rsp_valid, rsp_bit, rsp_presence, err_stuck, pin_drive, spu
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_bit, cmd_spu, pin_in,
    input  cmd_ready, rsp_valid, rsp_bit, rsp_presence, err_stuck, pin_drive, spu
  );
`else
  modport master (
    input  cmd_valid, cmd_op, cmd_bit, pin_in,
    output cmd_ready, rsp_valid, rsp_bit, rsp_presence, err_stuck, pin_drive
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_bit, pin_in,
    input  cmd_ready, rsp_valid, rsp_bit, rsp_presence, err_stuck, pin_drive
  );
`endif
endinterface

// File: rtl/onewire_master.sv
// onewire_master
// Bit-level 1-Wire bus initiator. Executes one RESET/presence, WRITE or READ
// time slot per accepted command and reports the sampled bus level.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    onewire_master_if.master (command/response handshake and pad)
// Timing parameters are in microseconds; CLK_DIV is clk cycles per microsecond.
// Optional feature, macro ONEWIRE_STRONG_PULLUP_EN: adds cmd_spu/spu so that a
// WRITE can be followed by a strong pull-up (parasite-power conversion).
module onewire_master #(
  parameter int CLK_DIV = 50,
  parameter int T_RSTL  = 480,
  parameter int T_PSAMP = 70,
  parameter int T_RSTH  = 410,
  parameter int T_LOW1  = 6,
  parameter int T_LOW0  = 60,
  parameter int T_RSAMP = 15,
  parameter int T_SLOT  = 70,
  parameter int T_REC   = 5
) (
  input logic              clk,
  input logic              reset,
  onewire_master_if.master bus
);

  localparam int MAX_A  = (T_RSTL > T_RSTH) ? T_RSTL : T_RSTH;
  localparam int MAX_US = (MAX_A > (T_SLOT + T_REC)) ? MAX_A : (T_SLOT + T_REC);
  localparam int UW     = $clog2(MAX_US + 1);
  localparam int PW     = $clog2(CLK_DIV);

  // Compare values are "last count before the boundary": the boundary edge
  // is the tick that would move the us counter onto the target value.
  localparam logic [PW-1:0] PRE_LAST     = PW'(CLK_DIV - 1);
  localparam logic [UW-1:0] RSTL_LAST    = UW'(T_RSTL - 1);
  localparam logic [UW-1:0] PSAMP_LAST   = UW'(T_PSAMP - 1);
  localparam logic [UW-1:0] RSTH_LAST    = UW'(T_RSTH - 1);
  localparam logic [UW-1:0] LOW1_LAST    = UW'(T_LOW1 - 1);
  localparam logic [UW-1:0] LOW0_LAST    = UW'(T_LOW0 - 1);
  localparam logic [UW-1:0] RSAMP_LAST   = UW'(T_RSAMP - 1);
  localparam logic [UW-1:0] SLOTEND_LAST = UW'(T_SLOT + T_REC - 1);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state_q;
  logic [1:0]    op_q;
  logic          bit_q;
  logic [PW-1:0] pre_q;
  logic [UW-1:0] us_q;
  logic          pin_meta_q;
  logic          pin_s_q;
  logic          cmd_ready_q;
  logic          rsp_valid_q;
  logic          rsp_bit_q;
  logic          rsp_presence_q;
  logic          err_stuck_q;
  logic          pin_drive_q;
`ifdef ONEWIRE_STRONG_PULLUP_EN
  logic          spu_req_q;
  logic          spu_q;
`endif

  logic          tick;
  logic [UW-1:0] low_last;
  logic [UW-1:0] samp_last;
  logic [UW-1:0] end_last;

  assign tick = (pre_q == PRE_LAST);

  // Phase boundaries for the latched command. RESET restarts the us counter
  // at release, slots keep counting from the falling edge.
  always_comb begin
    low_last  = LOW1_LAST;
    samp_last = RSAMP_LAST;
    end_last  = SLOTEND_LAST;
    if (op_q == OP_RESET) begin
      low_last  = RSTL_LAST;
      samp_last = PSAMP_LAST;
      end_last  = RSTH_LAST;
    end else if (op_q == OP_WRITE && !bit_q) begin
      low_last  = LOW0_LAST;
    end
  end

  // Two-flop synchronizer for the asynchronous pad. Resets to the idle
  // (pulled-up) level so a fresh reset never reports a stuck bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      pin_meta_q <= 1'b1;
      pin_s_q    <= 1'b1;
    end else begin
      pin_meta_q <= bus.pin_in;
      pin_s_q    <= pin_meta_q;
    end
  end

  // Command sequencer: timebase, sampling and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= OP_RESET;
      bit_q          <= 1'b0;
      pre_q          <= '0;
      us_q           <= '0;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_bit_q      <= 1'b0;
      rsp_presence_q <= 1'b0;
      err_stuck_q    <= 1'b0;
      pin_drive_q    <= 1'b0;
`ifdef ONEWIRE_STRONG_PULLUP_EN
      spu_req_q      <= 1'b0;
      spu_q          <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      err_stuck_q <= 1'b0;

      if (tick) begin
        pre_q <= '0;
        us_q  <= us_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end

      // The slot sample point can fall inside LOW (write-0), so it is not
      // tied to a single state; presence is only sampled after release.
      if (tick && us_q == samp_last) begin
        if (op_q == OP_RESET) begin
          if (state_q == HIGH) rsp_presence_q <= ~pin_s_q;
        end else if (state_q == LOW || state_q == HIGH) begin
          rsp_bit_q <= pin_s_q;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            bit_q       <= bus.cmd_bit;
            pre_q       <= '0;
            us_q        <= '0;
            cmd_ready_q <= 1'b0;
`ifdef ONEWIRE_STRONG_PULLUP_EN
            spu_req_q   <= bus.cmd_spu;
            spu_q       <= 1'b0;
`endif
            if (!pin_s_q) begin
              err_stuck_q    <= 1'b1;
              rsp_valid_q    <= 1'b1;
              rsp_bit_q      <= 1'b0;
              rsp_presence_q <= 1'b0;
              state_q        <= DONE;
            end else if (bus.cmd_op == OP_RSVD) begin
              rsp_valid_q <= 1'b1;
              rsp_bit_q   <= 1'b0;
              state_q     <= DONE;
            end else begin
              pin_drive_q <= 1'b1;
              state_q     <= LOW;
            end
          end
        end
        LOW: begin
          if (tick && us_q == low_last) begin
            pin_drive_q <= 1'b0;
            state_q     <= HIGH;
            if (op_q == OP_RESET) us_q <= '0;
          end
        end
        HIGH: begin
          if (tick && us_q == end_last) begin
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef ONEWIRE_STRONG_PULLUP_EN
            if (op_q == OP_WRITE && spu_req_q) spu_q <= 1'b1;
`endif
          end
        end
        DONE: begin
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_bit      = rsp_bit_q;
  assign bus.rsp_presence = rsp_presence_q;
  assign bus.err_stuck    = err_stuck_q;
  assign bus.pin_drive    = pin_drive_q;
`ifdef ONEWIRE_STRONG_PULLUP_EN
  assign bus.spu          = spu_q;
`endif

endmodule

// File: tb/tb_onewire_master.sv
// tb_onewire_master
// Bench for onewire_master with CLK_DIV=4 (one microsecond = 4 clk cycles).
// A behavioural device on the open-drain line answers resets with a presence
// pulse and can hold read slots low; results are compared against a table of
// hand-derived expectations, an arithmetic reference model for random slots,
// and hand-written corner-case sequences.
// Strong pull-up checks are compiled only with ONEWIRE_STRONG_PULLUP_EN.
`timescale 1ns/1ps
module tb_onewire_master;

  localparam int CLK_DIV = 4;
  localparam int CLK_NS  = 10;
  localparam int US_NS   = CLK_DIV * CLK_NS;
  localparam int T_RSTL  = 480;
  localparam int T_RSTH  = 410;
  localparam int T_LOW1  = 6;
  localparam int T_LOW0  = 60;
  localparam int T_SLOT  = 70;
  localparam int T_REC   = 5;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef struct {
    int   lowCycles;
    int   doneCycle;
    logic rspBit;
    logic presence;
    logic stuck;
    logic readyEarly;
    logic readyAfter;
    logic validAfter;
`ifdef ONEWIRE_STRONG_PULLUP_EN
    logic spuAtStart;
    logic spuAtDone;
    logic spuAfter;
    logic spuDrive;
`endif
  } result_t;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic       b;
    logic       devPresent;
    logic       devBit;
    logic       stuck;
    int         expLow;
    int         expDone;
    logic       expBit;
    logic       chkBit;
    logic       expPres;
    logic       chkPres;
    logic       expStuck;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic devPull    = 1'b0;
  logic stuckLow   = 1'b0;
  logic slotMode   = 1'b1;
  logic slotBit    = 1'b1;
  logic devPresent = 1'b0;
`ifdef ONEWIRE_STRONG_PULLUP_EN
  logic spuReq     = 1'b0;
`endif

  int checkCount = 0;
  int passCount  = 0;
  vec_t vecs[11];

  always #(CLK_NS / 2) clk = ~clk;

  onewire_master_if bus();

  // Open-drain line: low whenever anyone pulls it down.
  assign bus.pin_in = ~(bus.pin_drive | devPull | stuckLow);

  onewire_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  // Device model: in slot mode it holds the line for 30 us after a falling
  // edge when it has a 0 to return; otherwise it answers a long reset pulse
  // with a presence pulse 16..76 us after release.
  initial begin
    time fallTime;
    forever begin
      @(posedge bus.pin_drive);
      if (slotMode) begin
        if (!slotBit) begin
          devPull = 1'b1;
          #(30 * US_NS);
          devPull = 1'b0;
        end
      end else begin
        fallTime = $time;
        @(negedge bus.pin_drive);
        if (devPresent && ($time - fallTime) >= 400 * US_NS) begin
          #(16 * US_NS);
          devPull = 1'b1;
          #(60 * US_NS);
          devPull = 1'b0;
        end
      end
    end
  end

  initial begin
    #(5_000_000);
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Expected slot results from the timing rules: low width and slot length
  // in clk cycles, and the bus level the initiator sees at the sample point.
  function automatic void refModel(input logic [1:0] op, input logic b, input logic devBit,
                                   output int lowCyc, output int doneCyc, output logic bitOut);
    lowCyc  = 0;
    doneCyc = 0;
    bitOut  = 1'b0;
    if (op == OP_WRITE) begin
      lowCyc  = (b ? T_LOW1 : T_LOW0) * CLK_DIV;
      doneCyc = (T_SLOT + T_REC) * CLK_DIV;
      bitOut  = b & devBit;
    end else if (op == OP_READ) begin
      lowCyc  = T_LOW1 * CLK_DIV;
      doneCyc = (T_SLOT + T_REC) * CLK_DIV;
      bitOut  = devBit;
    end else if (op == OP_RESET) begin
      lowCyc  = T_RSTL * CLK_DIV;
      doneCyc = (T_RSTL + T_RSTH) * CLK_DIV;
    end
  endfunction

  // Issues one command from a negedge and observes it until the cycle after
  // rsp_valid; cycle k counts clk edges after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic b, output result_t r);
    int waitCnt;
    r.lowCycles  = 0;
    r.doneCycle  = -1;
    r.rspBit     = 1'b0;
    r.presence   = 1'b0;
    r.stuck      = 1'b0;
    r.readyEarly = 1'b0;
    r.readyAfter = 1'b0;
    r.validAfter = 1'b0;
`ifdef ONEWIRE_STRONG_PULLUP_EN
    r.spuAtStart = 1'b0;
    r.spuAtDone  = 1'b0;
    r.spuAfter   = 1'b0;
    r.spuDrive   = 1'b0;
    bus.cmd_spu  = spuReq;
`endif
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_bit   = b;
    waitCnt = 0;
    while (!bus.cmd_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      checkOutput("acceptTimeout", 0, 1);
      return;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if (bus.pin_drive) r.lowCycles++;
      if (bus.err_stuck) r.stuck = 1'b1;
      if (bus.cmd_ready) r.readyEarly = 1'b1;
`ifdef ONEWIRE_STRONG_PULLUP_EN
      if (k == 0) r.spuAtStart = bus.spu;
      if (bus.spu && bus.pin_drive) r.spuDrive = 1'b1;
`endif
      if (bus.rsp_valid) begin
        r.doneCycle = k;
        r.rspBit    = bus.rsp_bit;
        r.presence  = bus.rsp_presence;
`ifdef ONEWIRE_STRONG_PULLUP_EN
        r.spuAtDone = bus.spu;
`endif
        break;
      end
      @(negedge clk);
    end
    if (r.doneCycle < 0) begin
      checkOutput("responseTimeout", 0, 1);
      return;
    end
    @(negedge clk);
    r.readyAfter = bus.cmd_ready;
    r.validAfter = bus.rsp_valid;
`ifdef ONEWIRE_STRONG_PULLUP_EN
    r.spuAfter   = bus.spu;
`endif
  endtask

  initial begin
    result_t    r;
    logic [1:0] op;
    logic       b;
    logic       db;
    int         expLow;
    int         expDone;
    logic       expBit;
    logic [63:0] romData;
    logic [63:0] romWord;
    logic       seen;

    vecs[0]  = '{"resetDev",    OP_RESET, 1'b0, 1'b1, 1'b1, 1'b0, 1920, 3560, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{"write0",      OP_WRITE, 1'b0, 1'b0, 1'b1, 1'b0,  240,  300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"write1",      OP_WRITE, 1'b1, 1'b0, 1'b1, 1'b0,   24,  300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"write1Held",  OP_WRITE, 1'b1, 1'b0, 1'b0, 1'b0,   24,  300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"read0",       OP_READ,  1'b0, 1'b0, 1'b0, 1'b0,   24,  300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"read1",       OP_READ,  1'b0, 1'b0, 1'b1, 1'b0,   24,  300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"reserved",    OP_RSVD,  1'b1, 1'b0, 1'b1, 1'b0,    0,    0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"stuckWrite",  OP_WRITE, 1'b1, 1'b0, 1'b1, 1'b1,    0,    0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{"resetNoDev",  OP_RESET, 1'b0, 1'b0, 1'b1, 1'b0, 1920, 3560, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"resetDev2",   OP_RESET, 1'b0, 1'b1, 1'b1, 1'b0, 1920, 3560, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{"stuckReset",  OP_RESET, 1'b0, 1'b1, 1'b1, 1'b1,    0,    0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_bit   = 1'b0;
`ifdef ONEWIRE_STRONG_PULLUP_EN
    bus.cmd_spu   = 1'b0;
`endif
    repeat (5) @(negedge clk);
    checkOutput("reset.cmd_ready",    bus.cmd_ready, 1);
    checkOutput("reset.pin_drive",    bus.pin_drive, 0);
    checkOutput("reset.rsp_valid",    bus.rsp_valid, 0);
    checkOutput("reset.rsp_bit",      bus.rsp_bit, 0);
    checkOutput("reset.rsp_presence", bus.rsp_presence, 0);
    checkOutput("reset.err_stuck",    bus.err_stuck, 0);
`ifdef ONEWIRE_STRONG_PULLUP_EN
    checkOutput("reset.spu",          bus.spu, 0);
`endif
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Table of directed commands; rows 1 and 2 run back-to-back.
    for (int i = 0; i < 11; i++) begin
      devPresent = vecs[i].devPresent;
      slotMode   = (vecs[i].op != OP_RESET);
      slotBit    = vecs[i].devBit;
      if (vecs[i].stuck) begin
        stuckLow = 1'b1;
        repeat (4) @(negedge clk);
      end
      applyStimulus(vecs[i].op, vecs[i].b, r);
      if (vecs[i].stuck) begin
        stuckLow = 1'b0;
        repeat (4) @(negedge clk);
      end
      checkOutput({vecs[i].name, ".lowCycles"},  r.lowCycles, vecs[i].expLow);
      checkOutput({vecs[i].name, ".doneCycle"},  r.doneCycle, vecs[i].expDone);
      checkOutput({vecs[i].name, ".err_stuck"},  r.stuck, vecs[i].expStuck);
      checkOutput({vecs[i].name, ".readyEarly"}, r.readyEarly, 0);
      checkOutput({vecs[i].name, ".readyAfter"}, r.readyAfter, 1);
      checkOutput({vecs[i].name, ".validAfter"}, r.validAfter, 0);
      if (vecs[i].chkBit)  checkOutput({vecs[i].name, ".rsp_bit"},      r.rspBit, vecs[i].expBit);
      if (vecs[i].chkPres) checkOutput({vecs[i].name, ".rsp_presence"}, r.presence, vecs[i].expPres);
    end

    // Random slots against the reference model.
    devPresent = 1'b0;
    slotMode   = 1'b1;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(1, 3));
      b  = 1'($urandom_range(0, 1));
      db = 1'($urandom_range(0, 1));
      slotBit = db;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(op, b, r);
      refModel(op, b, db, expLow, expDone, expBit);
      checkOutput($sformatf("rand%0d.lowCycles", i), r.lowCycles, expLow);
      checkOutput($sformatf("rand%0d.doneCycle", i), r.doneCycle, expDone);
      checkOutput($sformatf("rand%0d.rsp_bit", i),   r.rspBit, expBit);
    end

    // 64 READ slots reassembling a ROM code, LSB first.
    romData = 64'hbe000008e52f8e01;
    romWord = '0;
    for (int i = 0; i < 64; i++) begin
      slotBit = romData[i];
      applyStimulus(OP_READ, 1'b0, r);
      romWord[i] = r.rspBit;
    end
    checkOutput("rom.word", romWord, 64'hbe000008e52f8e01);

    // Reset in the middle of a RESET low phase.
    slotMode      = 1'b0;
    devPresent    = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_RESET;
    bus.cmd_bit   = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("abort.driving", bus.pin_drive, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort.release", bus.pin_drive, 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4000) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    checkOutput("abort.noRspValid", seen, 0);
    checkOutput("abort.cmd_ready",  bus.cmd_ready, 1);

`ifdef ONEWIRE_STRONG_PULLUP_EN
    // Strong pull-up after WRITE with cmd_spu, cleared by the next accept.
    slotMode = 1'b1;
    slotBit  = 1'b1;
    spuReq   = 1'b1;
    applyStimulus(OP_WRITE, 1'b1, r);
    checkOutput("spu.atDone",  r.spuAtDone, 1);
    checkOutput("spu.after",   r.spuAfter, 1);
    checkOutput("spu.noDrive", r.spuDrive, 0);
    repeat (5) @(negedge clk);
    checkOutput("spu.holds",   bus.spu, 1);
    spuReq = 1'b0;
    applyStimulus(OP_WRITE, 1'b0, r);
    checkOutput("spu.clearAtAccept", r.spuAtStart, 0);
    checkOutput("spu.offAtDone",     r.spuAtDone, 0);
    checkOutput("spu.noDrive2",      r.spuDrive, 0);
    spuReq = 1'b1;
    applyStimulus(OP_READ, 1'b0, r);
    checkOutput("spu.readNoSpu",     r.spuAtDone, 0);
    spuReq = 1'b0;
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
